// File: rtl/jt12_wr_sched.sv
// Write scheduler for the jt12 CPU port: round-robin arbitration between host and
// init sequencer, then a timed address / gap / data / wait sequence on cs_n/wr_n/addr/din.
module jt12_wr_sched #(
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 1,
  parameter int WAIT_CYC  = 32,
  parameter int CW        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_reg,
  input  logic [15:0] req_val,
  output logic [1:0]  req_ready,
  output logic        cs_n,
  output logic        wr_n,
  output logic        addr,
  output logic [7:0]  din,
  output logic        busy,
  output logic        last_gnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_APH  = 3'd1,
    S_GAP  = 3'd2,
    S_DPH  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_gnt_q, last_gnt_d;
  logic [7:0]      val_q, val_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic            addr_q, addr_d;
  logic [7:0]      din_q, din_d;

  logic            gnt;
  logic [CW-1:0]   phase_last;
  logic [7:0]      sel_reg;
  logic [7:0]      sel_val;

  // With both requesters pending, the one not served last wins.
  assign gnt     = (&req_valid) ? ~last_gnt_q : req_valid[1];
  assign sel_reg = gnt ? req_reg[15:8] : req_reg[7:0];
  assign sel_val = gnt ? req_val[15:8] : req_val[7:0];

  always_comb begin
    phase_last = '0;
    case (state_q)
      S_APH:   phase_last = PULSE_LAST;
      S_GAP:   phase_last = GAP_LAST;
      S_DPH:   phase_last = PULSE_LAST;
      S_WAIT:  phase_last = WAIT_LAST;
      default: phase_last = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    val_d      = val_q;
    cs_n_d     = cs_n_q;
    wr_n_d     = wr_n_q;
    addr_d     = addr_q;
    din_d      = din_q;
    req_ready  = 2'b00;

    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            req_ready  = gnt ? 2'b10 : 2'b01;
            state_d    = S_APH;
            cnt_d      = '0;
            last_gnt_d = gnt;
            val_d      = sel_val;
            cs_n_d     = 1'b0;
            wr_n_d     = 1'b0;
            addr_d     = 1'b0;
            din_d      = sel_reg;
          end
        end
        S_APH, S_GAP, S_DPH, S_WAIT: begin
          if (cnt_q == phase_last) begin
            cnt_d = '0;
            case (state_q)
              S_APH: begin
                state_d = S_GAP;
                wr_n_d  = 1'b1;
              end
              S_GAP: begin
                state_d = S_DPH;
                wr_n_d  = 1'b0;
                addr_d  = 1'b1;
                din_d   = val_q;
              end
              S_DPH: begin
                state_d = S_WAIT;
                cs_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                addr_d  = 1'b0;
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          // Unreachable encodings fall back to an idle bus.
          state_d = S_IDLE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          addr_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      val_q      <= 8'h00;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      addr_q     <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      val_q      <= val_d;
      cs_n_q     <= cs_n_d;
      wr_n_q     <= wr_n_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign cs_n     = cs_n_q;
  assign wr_n     = wr_n_q;
  assign addr     = addr_q;
  assign din      = din_q;
  assign busy     = (state_q != S_IDLE);
  assign last_gnt = last_gnt_q;

endmodule

// File: tb/tb_jt12_wr_sched.sv
// Directed bench for jt12_wr_sched: table of writes with hand-computed grants and bus
// values, plus hand sequences for cen stretching, mid-write reset and dropped requests.
module tb_jt12_wr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_reg = 16'h0000;
  logic [15:0] req_val = 16'h0000;
  logic [1:0]  req_ready;
  logic        cs_n, wr_n, addr, busy, last_gnt;
  logic [7:0]  din;

  int n_cmp = 0;
  int n_bad = 0;

  jt12_wr_sched #(.PULSE_CYC(1), .GAP_CYC(1), .WAIT_CYC(32), .CW(8)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .req_valid(req_valid), .req_reg(req_reg), .req_val(req_val),
    .req_ready(req_ready), .cs_n(cs_n), .wr_n(wr_n), .addr(addr),
    .din(din), .busy(busy), .last_gnt(last_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] reg0, val0, reg1, val1;
    logic       drop;
    logic       exp_gnt;
    logic [7:0] exp_reg, exp_val;
  } wr_vec_t;

  wr_vec_t tbl [8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] bus();
    return {busy, cs_n, wr_n, addr, din};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // One full write with cen=1: accept, APH, GAP, DPH, WAIT, back to IDLE.
  task automatic write_check(input wr_vec_t v);
    int waited;
    int n;
    int rdy_busy;
    req_valid = v.valid;
    req_reg   = {v.reg1, v.reg0};
    req_val   = {v.val1, v.val0};
    #1;
    waited = 0;
    while (req_ready == 2'b00 && waited < 100) begin
      cyc();
      waited++;
    end
    chk("accept_wait", waited, 0);
    chk("grant", {30'd0, req_ready}, v.exp_gnt ? 32'd2 : 32'd1);
    cyc();
    if (v.drop) req_valid = 2'b00;
    chk("aph_bus", bus(), {1'b1, 1'b0, 1'b0, 1'b0, v.exp_reg});
    chk("last_gnt", last_gnt, v.exp_gnt);
    cyc();
    chk("gap_bus", bus(), {1'b1, 1'b0, 1'b1, 1'b0, v.exp_reg});
    cyc();
    chk("dph_bus", bus(), {1'b1, 1'b0, 1'b0, 1'b1, v.exp_val});
    n = 0;
    rdy_busy = 0;
    while (busy && n < 100) begin
      cyc();
      n++;
      if (busy && (req_ready != 2'b00)) rdy_busy++;
    end
    chk("dph_to_idle", n, 33);
    chk("ready_busy", rdy_busy, 0);
    chk("idle_bus", bus(), {1'b0, 1'b1, 1'b1, 1'b0, v.exp_val});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] tr [72];
    logic [11:0] e;
    int errs;
    int edges;

    //           valid  reg0   val0   reg1   val1   drop  gnt   reg    val
    tbl[0] = '{2'b01, 8'h28, 8'h10, 8'hEE, 8'hEE, 1'b1, 1'b0, 8'h28, 8'h10};
    tbl[1] = '{2'b11, 8'h20, 8'h01, 8'h30, 8'h02, 1'b0, 1'b0, 8'h20, 8'h01};
    tbl[2] = '{2'b11, 8'h21, 8'h03, 8'h31, 8'h04, 1'b0, 1'b1, 8'h31, 8'h04};
    tbl[3] = '{2'b11, 8'h22, 8'h05, 8'h32, 8'h06, 1'b0, 1'b0, 8'h22, 8'h05};
    tbl[4] = '{2'b11, 8'h23, 8'h07, 8'h33, 8'h08, 1'b0, 1'b1, 8'h33, 8'h08};
    tbl[5] = '{2'b10, 8'hFF, 8'hFF, 8'hB0, 8'h07, 1'b0, 1'b1, 8'hB0, 8'h07};
    tbl[6] = '{2'b10, 8'hFF, 8'hFF, 8'hA4, 8'h24, 1'b0, 1'b1, 8'hA4, 8'h24};
    tbl[7] = '{2'b10, 8'hFF, 8'hFF, 8'hA0, 8'h0F, 1'b1, 1'b1, 8'hA0, 8'h0F};

    // T1: reset state, then a single host write.
    do_reset();
    chk("rst_bus", bus(), {1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    chk("rst_last_gnt", last_gnt, 1'b1);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    write_check(tbl[0]);

    // T2/T3: round robin with both held, then req1 alone back to back.
    do_reset();
    for (int i = 1; i < 8; i++) write_check(tbl[i]);

    // T4: cen alternates 1/0, every phase doubles.
    do_reset();
    cen = 1'b1;
    req_valid = 2'b01;
    req_reg = 16'hEE28;
    req_val = 16'hEE10;
    #1;
    chk("t4_ready", {30'd0, req_ready}, 32'd1);
    for (int k = 0; k < 72; k++) begin
      cyc();
      tr[k] = bus();
      if (k == 0) req_valid = 2'b00;
      cen = (k % 2 == 1);
    end
    cen = 1'b1;
    errs = 0;
    for (int k = 0; k < 72; k++) begin
      if (k < 2)       e = {1'b1, 1'b0, 1'b0, 1'b0, 8'h28};
      else if (k < 4)  e = {1'b1, 1'b0, 1'b1, 1'b0, 8'h28};
      else if (k < 6)  e = {1'b1, 1'b0, 1'b0, 1'b1, 8'h10};
      else if (k < 70) e = {1'b1, 1'b1, 1'b1, 1'b0, 8'h10};
      else             e = {1'b0, 1'b1, 1'b1, 1'b0, 8'h10};
      if (tr[k] !== e) begin
        errs++;
        if (errs == 1) chk("t4_trace_first", {20'd0, tr[k]}, {20'd0, e});
      end
    end
    chk("t4_trace_errs", errs, 0);
    edges = 0;
    for (int k = 1; k < 72; k++) if (tr[k][9] !== tr[k-1][9]) edges++;
    chk("t4_wr_n_edges", edges, 3);

    // T5: reset during GAP abandons the write and restores requester-0 priority.
    do_reset();
    req_valid = 2'b10;
    req_reg = 16'h2828;
    req_val = 16'h1010;
    cyc();
    req_valid = 2'b00;
    chk("t5_last_gnt", last_gnt, 1'b1);
    cyc();
    chk("t5_gap", bus(), {1'b1, 1'b0, 1'b1, 1'b0, 8'h28});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_rst_bus", bus(), {1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    chk("t5_rst_last_gnt", last_gnt, 1'b1);
    errs = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus() !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) errs++;
    end
    chk("t5_no_dph", errs, 0);
    write_check('{2'b11, 8'h44, 8'h55, 8'h66, 8'h77, 1'b1, 1'b0, 8'h44, 8'h55});

    // T6: a one-cycle req0 pulse while busy is never accepted.
    req_valid = 2'b10;
    req_reg = 16'hB0FF;
    req_val = 16'h07FF;
    #1;
    chk("t6_ready", {30'd0, req_ready}, 32'd2);
    cyc();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) cyc();
    req_valid = 2'b01;
    req_reg = 16'h0033;
    #1;
    chk("t6_pulse_ready", {30'd0, req_ready}, 32'd0);
    cyc();
    req_valid = 2'b00;
    edges = 0;
    while (busy && edges < 100) begin
      cyc();
      edges++;
    end
    chk("t6_busy_done", busy, 1'b0);
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (busy !== 1'b0 || cs_n !== 1'b1 || wr_n !== 1'b1 || req_ready !== 2'b00) errs++;
    end
    chk("t6_stays_idle", errs, 0);
    chk("t6_last_gnt", last_gnt, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
